// File: rtl/sram_like_arbiter.sv
// Two-master arbiter for one SRAM-like memory port: data beats fetch, a stalled grant is locked
// until its address handshake, and an in-order owner FIFO routes responses back.
module sram_like_arbiter #(
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned OWNER_AW  = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CntW = OWNER_AW + 1;
    localparam logic [CntW-1:0]     MaxCnt  = CntW'(MAX_OUTST);
    localparam logic [OWNER_AW-1:0] LastPtr = OWNER_AW'(MAX_OUTST - 1);

    // Owner FIFO entries: 0 = inst, 1 = data.
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [OWNER_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OWNER_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 lock_q, lock_d;
    logic                 lock_owner_q, lock_owner_d;

    logic empty, full, any_req, sel_data, accept, pop, head;

    function automatic logic [OWNER_AW-1:0] ptr_inc(input logic [OWNER_AW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == MaxCnt);
        any_req  = inst_req | data_req;
        sel_data = lock_q ? lock_owner_q : data_req;
        // Full is taken from the registered count only, so m_data_ok never reaches m_req.
        m_req    = any_req & ~full & ~reset;
        accept   = m_req & m_addr_ok;
        pop      = m_data_ok & ~empty & ~reset;
        head     = owner_q[rd_ptr_q];
    end

    always_comb begin
        m_wr         = 1'b0;
        m_size       = '0;
        m_addr       = '0;
        m_wdata      = '0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = '0;
        data_rdata   = '0;
        if (!reset) begin
            if (any_req) begin
                if (sel_data) begin
                    m_wr    = data_wr;
                    m_size  = data_size;
                    m_addr  = data_addr;
                    m_wdata = data_wdata;
                end else begin
                    m_wr    = inst_wr;
                    m_size  = inst_size;
                    m_addr  = inst_addr;
                    m_wdata = inst_wdata;
                end
            end
            inst_addr_ok = accept & ~sel_data;
            data_addr_ok = accept & sel_data;
            inst_data_ok = pop & ~head;
            data_data_ok = pop & head;
            inst_rdata   = m_rdata;
            data_rdata   = m_rdata;
        end
    end

    always_comb begin
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;

        if (accept) begin
            owner_d[wr_ptr_q] = sel_data;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({accept, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if (accept) begin
            lock_d = 1'b0;
        end else if (m_req && !m_addr_ok) begin
            lock_d       = 1'b1;
            lock_owner_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a cycle table for basic/conflict traffic, then
// hand-written sequences for lock hold, backpressure, ordering and reset.
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int stray_seen = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(.MAX_OUTST(2), .OWNER_AW(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_size       (m_size),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata)
    );

    // A response nobody owns is a protocol error; count sightings for the final check.
    always @(negedge clk) begin
        if (!reset && m_data_ok && !inst_data_ok && !data_data_ok) stray_seen++;
    end

    typedef struct {
        logic        ireq;
        logic        dreq;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic        maok;
        logic        mdok;
        logic [31:0] rd;
        logic        rst;
        logic        e_mreq;
        logic [31:0] e_maddr;
        logic        e_wr;
        logic        e_iaok;
        logic        e_daok;
        logic        e_idok;
        logic        e_ddok;
    } vec_t;

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    // Inst is always a word fetch; data is always a half-word store with wdata = ~addr.
    task automatic step(input string tag, input vec_t v);
        logic [1:0] e_size;
        reset      = v.rst;
        inst_req   = v.ireq;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_addr  = v.iaddr;
        inst_wdata = 32'h0;
        data_req   = v.dreq;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_addr  = v.daddr;
        data_wdata = ~v.daddr;
        m_addr_ok  = v.maok;
        m_data_ok  = v.mdok;
        m_rdata    = v.rd;
        e_size = v.e_wr ? 2'd1 : ((v.e_maddr != 32'h0) ? 2'd2 : 2'd0);
        @(negedge clk);
        chk(tag, "m_req", {31'h0, m_req}, {31'h0, v.e_mreq});
        chk(tag, "m_addr", m_addr, v.e_maddr);
        chk(tag, "m_wr", {31'h0, m_wr}, {31'h0, v.e_wr});
        chk(tag, "m_size", {30'h0, m_size}, {30'h0, e_size});
        chk(tag, "m_wdata", m_wdata, v.e_wr ? ~v.e_maddr : 32'h0);
        chk(tag, "inst_addr_ok", {31'h0, inst_addr_ok}, {31'h0, v.e_iaok});
        chk(tag, "data_addr_ok", {31'h0, data_addr_ok}, {31'h0, v.e_daok});
        chk(tag, "inst_data_ok", {31'h0, inst_data_ok}, {31'h0, v.e_idok});
        chk(tag, "data_data_ok", {31'h0, data_data_ok}, {31'h0, v.e_ddok});
        if (v.e_idok) chk(tag, "inst_rdata", inst_rdata, v.rd);
        if (v.e_ddok) chk(tag, "data_rdata", data_rdata, v.rd);
        if (v.rst) begin
            chk(tag, "inst_rdata_rst", inst_rdata, 32'h0);
            chk(tag, "data_rdata_rst", data_rdata, 32'h0);
        end
        @(posedge clk);
        #1;
    endtask

    // Positional builder: inputs, then expected m_req/m_addr/m_wr/iaok/daok/idok/ddok.
    function automatic vec_t mk(input logic ireq, input logic dreq, input logic [31:0] iaddr,
                                input logic [31:0] daddr, input logic maok, input logic mdok,
                                input logic [31:0] rd, input logic rst, input logic e_mreq,
                                input logic [31:0] e_maddr, input logic e_wr,
                                input logic e_iaok, input logic e_daok,
                                input logic e_idok, input logic e_ddok);
        vec_t v;
        v = '{ireq, dreq, iaddr, daddr, maok, mdok, rd, rst,
              e_mreq, e_maddr, e_wr, e_iaok, e_daok, e_idok, e_ddok};
        return v;
    endfunction

    vec_t tbl [8];

    initial begin
        //             ireq dreq iaddr          daddr          aok dok rdata          rst
        //             mreq maddr          wr  iaok daok idok ddok
        tbl[0] = mk(1, 0, 32'hBFC00000, 32'h0,        1, 0, 32'h0,        0,
                    1, 32'hBFC00000, 0, 1, 0, 0, 0);
        tbl[1] = mk(0, 0, 32'h0,        32'h0,        0, 1, 32'h3C1D0000, 0,
                    0, 32'h0,        0, 0, 0, 1, 0);
        tbl[2] = mk(0, 0, 32'h0,        32'h0,        1, 0, 32'h0,        0,
                    0, 32'h0,        0, 0, 0, 0, 0);
        tbl[3] = mk(1, 1, 32'h00001000, 32'h00002000, 1, 0, 32'h0,        0,
                    1, 32'h00002000, 1, 0, 1, 0, 0);
        tbl[4] = mk(1, 0, 32'h00001000, 32'h0,        1, 0, 32'h0,        0,
                    1, 32'h00001000, 0, 1, 0, 0, 0);
        // Full: request visible on m_addr but m_req held low; response pops the data entry.
        tbl[5] = mk(1, 1, 32'h00001004, 32'h00002004, 1, 1, 32'h000000AA, 0,
                    0, 32'h00002004, 1, 0, 0, 0, 1);
        // Push and pop together, write pointer wraps.
        tbl[6] = mk(1, 1, 32'h00001004, 32'h00002004, 1, 1, 32'h000000BB, 0,
                    1, 32'h00002004, 1, 0, 1, 1, 0);
        tbl[7] = mk(0, 0, 32'h0,        32'h0,        0, 1, 32'h000000CC, 0,
                    0, 32'h0,        0, 0, 0, 0, 1);

        // Reset state: outputs held at zero while reset is high.
        step("reset0", mk(1, 1, 32'h10, 32'h20, 1, 1, 32'h5, 1, 0, 32'h0, 0, 0, 0, 0, 0));
        step("reset1", mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 8; i++) begin
            step($sformatf("tbl%0d", i), tbl[i]);
        end

        // Lock hold: stalled inst grant keeps the port even after data starts requesting.
        step("lock0", mk(1, 0, 32'h100, 32'h0,   0, 0, 32'h0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
        step("lock1", mk(1, 1, 32'h100, 32'h200, 0, 0, 32'h0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
        step("lock2", mk(1, 1, 32'h100, 32'h200, 0, 0, 32'h0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
        step("lock3", mk(1, 1, 32'h100, 32'h200, 1, 0, 32'h0, 0, 1, 32'h100, 0, 1, 0, 0, 0));
        step("lock4", mk(0, 1, 32'h0,   32'h200, 1, 0, 32'h0, 0, 1, 32'h200, 1, 0, 1, 0, 0));
        step("lock5", mk(0, 0, 32'h0, 32'h0, 0, 1, 32'h61, 0, 0, 32'h0, 0, 0, 0, 1, 0));
        step("lock6", mk(0, 0, 32'h0, 32'h0, 0, 1, 32'h62, 0, 0, 32'h0, 0, 0, 0, 0, 1));

        // Full backpressure: a same-cycle pop does not release m_req.
        step("full0", mk(1, 0, 32'h300, 32'h0, 1, 0, 32'h0,  0, 1, 32'h300, 0, 1, 0, 0, 0));
        step("full1", mk(1, 0, 32'h304, 32'h0, 1, 0, 32'h0,  0, 1, 32'h304, 0, 1, 0, 0, 0));
        step("full2", mk(1, 0, 32'h308, 32'h0, 1, 0, 32'h0,  0, 0, 32'h308, 0, 0, 0, 0, 0));
        step("full3", mk(1, 0, 32'h308, 32'h0, 1, 1, 32'h11, 0, 0, 32'h308, 0, 0, 0, 1, 0));
        step("full4", mk(1, 0, 32'h308, 32'h0, 1, 0, 32'h0,  0, 1, 32'h308, 0, 1, 0, 0, 0));
        step("full5", mk(0, 0, 32'h0,   32'h0, 0, 1, 32'h22, 0, 0, 32'h0,   0, 0, 0, 1, 0));
        step("full6", mk(0, 0, 32'h0,   32'h0, 0, 1, 32'h33, 0, 0, 32'h0,   0, 0, 0, 1, 0));

        // Ordering: inst, data, inst accepted; responses 1,2,3 go back in that order.
        step("ord0", mk(1, 0, 32'h400, 32'h0,   1, 0, 32'h0, 0, 1, 32'h400, 0, 1, 0, 0, 0));
        step("ord1", mk(0, 1, 32'h0,   32'h500, 1, 0, 32'h0, 0, 1, 32'h500, 1, 0, 1, 0, 0));
        step("ord2", mk(1, 0, 32'h404, 32'h0,   1, 1, 32'h1, 0, 0, 32'h404, 0, 0, 0, 1, 0));
        step("ord3", mk(1, 0, 32'h404, 32'h0,   1, 1, 32'h2, 0, 1, 32'h404, 0, 1, 0, 0, 1));
        step("ord4", mk(0, 0, 32'h0,   32'h0,   0, 1, 32'h3, 0, 0, 32'h0,   0, 0, 0, 1, 0));

        // Reset with two outstanding, then a stray response; FIFO must really be empty.
        step("rst0", mk(1, 0, 32'h600, 32'h0,   1, 0, 32'h0, 0, 1, 32'h600, 0, 1, 0, 0, 0));
        step("rst1", mk(0, 1, 32'h0,   32'h700, 1, 0, 32'h0, 0, 1, 32'h700, 1, 0, 1, 0, 0));
        step("rst2", mk(1, 1, 32'h600, 32'h700, 1, 1, 32'hDEAD, 1, 0, 32'h0, 0, 0, 0, 0, 0));
        step("rst3", mk(0, 0, 32'h0,   32'h0,   0, 1, 32'h99, 0, 0, 32'h0,   0, 0, 0, 0, 0));
        step("rst4", mk(1, 0, 32'h800, 32'h0,   1, 0, 32'h0,  0, 1, 32'h800, 0, 1, 0, 0, 0));
        step("rst5", mk(1, 0, 32'h804, 32'h0,   1, 0, 32'h0,  0, 1, 32'h804, 0, 1, 0, 0, 0));
        step("rst6", mk(1, 0, 32'h808, 32'h0,   1, 0, 32'h0,  0, 0, 32'h808, 0, 0, 0, 0, 0));
        step("rst7", mk(0, 0, 32'h0,   32'h0,   0, 1, 32'h44, 0, 0, 32'h0,   0, 0, 0, 1, 0));
        step("rst8", mk(0, 0, 32'h0,   32'h0,   0, 1, 32'h55, 0, 0, 32'h0,   0, 0, 0, 1, 0));

        chk("stray", "stray_responses", stray_seen, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
